banco_registros_param: RTL and testbench

//  Parametrised register file for the datapath, successor of the fixed 32x32 bank.
//  Two combinational read ports and one clocked write port with same-cycle write->read bypass.

---
 rtl/banco_registros_param_pkg.sv | 17 +
 rtl/banco_fill_fsm.sv | 83 ++++++++
 rtl/banco_registros_param.sv | 102 ++++++++++
 tb/tb_banco_registros_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/banco_registros_param_pkg.sv
// Shared definitions for the parametrised register bank: fill FSM states and depth helper.
package banco_registros_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/banco_fill_fsm.sv
// Fill engine: sweeps a latched value into every entry, one per cycle, and flags writes lost meanwhile.
module banco_fill_fsm
    import banco_registros_param_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_req,
    input  logic [DATA_W-1:0] fill_val,
    input  logic              enw,
    output fill_state_e       state,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_we,
    output logic              busy,
    output logic              fill_done,
    output logic              wr_drop
);

    localparam int                DEPTH     = depth_of(ADDR_W);
    // One extra pointer bit keeps the terminal compare exact for any ADDR_W.
    localparam logic [ADDR_W:0]   LAST_PTR  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FIRST_PTR = (ZERO_REG != 0) ? (ADDR_W + 1)'(1) : '0;
    localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W + 1)'(1);

    fill_state_e       state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0] latch_q, latch_d;
    logic              wr_drop_q, wr_drop_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            latch_q   <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            latch_q   <= latch_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        latch_d   = latch_q;
        wr_drop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_req) begin
                    state_d = ST_FILL;
                    ptr_d   = FIRST_PTR;
                    latch_d = fill_val;
                end
            end
            ST_FILL: begin
                wr_drop_d = enw;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_DONE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_ONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign state     = state_q;
    assign fill_addr = ptr_q[ADDR_W-1:0];
    assign fill_data = latch_q;
    assign fill_we   = (state_q == ST_FILL);
    assign busy      = (state_q == ST_FILL);
    assign fill_done = (state_q == ST_DONE);
    assign wr_drop   = wr_drop_q;

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised register file: two combinational read ports, one clocked write port, fill engine.
module banco_registros_param
    import banco_registros_param_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ar1,
    input  logic [ADDR_W-1:0] ar2,
    output logic [DATA_W-1:0] dr1,
    output logic [DATA_W-1:0] dr2,
    input  logic [ADDR_W-1:0] aw,
    input  logic [DATA_W-1:0] dw,
    input  logic              enw,
    input  logic              fill_req,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              fill_done,
    output logic              wr_drop
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    fill_state_e       fill_state;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              fill_we;
    logic              aw_is_zero_reg;
    logic              norm_we;
    logic              bypass_en;

    banco_fill_fsm #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_fill_fsm (
        .clk      (clk),
        .rst      (rst),
        .fill_req (fill_req),
        .fill_val (fill_val),
        .enw      (enw),
        .state    (fill_state),
        .fill_addr(fill_addr),
        .fill_data(fill_data),
        .fill_we  (fill_we),
        .busy     (busy),
        .fill_done(fill_done),
        .wr_drop  (wr_drop)
    );

    assign aw_is_zero_reg = (ZERO_REG != 0) && (aw == '0);
    // The port is locked out only while sweeping; DONE takes writes normally.
    assign norm_we        = enw && (fill_state != ST_FILL) && !aw_is_zero_reg;
    assign bypass_en      = (BYPASS != 0) && enw && (fill_state == ST_IDLE) && !aw_is_zero_reg;

    always_comb begin
        mem_d = mem_q;
        // On the acceptance edge the write lands first; the sweep overwrites it later.
        if (norm_we) begin
            mem_d[aw] = dw;
        end
        if (fill_we) begin
            mem_d[fill_addr] = fill_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        dr1 = mem_q[ar1];
        if (bypass_en && (ar1 == aw)) begin
            dr1 = dw;
        end
        if ((ZERO_REG != 0) && (ar1 == '0)) begin
            dr1 = '0;
        end
    end

    always_comb begin
        dr2 = mem_q[ar2];
        if (bypass_en && (ar2 == aw)) begin
            dr2 = dw;
        end
        if ((ZERO_REG != 0) && (ar2 == '0)) begin
            dr2 = '0;
        end
    end

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param: bypass and non-bypass instances share all inputs.
module tb_banco_registros_param;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ar1, ar2, aw;
    logic [DW-1:0] dw, fill_val;
    logic          enw, fill_req;
    logic [DW-1:0] dr1, dr2, nb_dr1, nb_dr2;
    logic          busy, fill_done, wr_drop;
    logic          nb_busy, nb_fill_done, nb_wr_drop;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    banco_registros_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .ar1(ar1), .ar2(ar2), .dr1(dr1), .dr2(dr2),
        .aw(aw), .dw(dw), .enw(enw), .fill_req(fill_req), .fill_val(fill_val),
        .busy(busy), .fill_done(fill_done), .wr_drop(wr_drop)
    );

    banco_registros_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .ar1(ar1), .ar2(ar2), .dr1(nb_dr1), .dr2(nb_dr2),
        .aw(aw), .dw(dw), .enw(enw), .fill_req(fill_req), .fill_val(fill_val),
        .busy(nb_busy), .fill_done(nb_fill_done), .wr_drop(nb_wr_drop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles from now until busy drops, capped so a stuck FSM still terminates.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        for (int a = 0; a < DEPTH; a++) begin
            ar1 = AW'(a);
            ar2 = AW'(DEPTH - 1 - a);
            #1;
            n_cmp++; if (dr1 !== '0) begin n_bad++; $display("FAIL reset_dr1[%0d]: got %0h expected 0", a, dr1); end
            n_cmp++; if (dr2 !== '0) begin n_bad++; $display("FAIL reset_dr2[%0d]: got %0h expected 0", a, dr2); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (fill_done !== 1'b0 || nb_fill_done !== 1'b0) begin n_bad++; $display("FAIL reset_fill_done: got %b expected 0", fill_done); end
        n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL reset_wr_drop: got %b expected 0", wr_drop); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        step();
        aw = 5'd3; dw = 32'd200; enw = 1'b1; ar1 = 5'd3; ar2 = 5'd4;
        #1;
        n_cmp++; if (dr1 !== 32'd200) begin n_bad++; $display("FAIL bypass_dr1: got %0d expected 200", dr1); end
        n_cmp++; if (nb_dr1 !== 32'd0) begin n_bad++; $display("FAIL nobypass_old: got %0d expected 0", nb_dr1); end
        n_cmp++; if (dr2 !== 32'd0) begin n_bad++; $display("FAIL unrelated_dr2: got %0d expected 0", dr2); end
        step();
        enw = 1'b0;
        #1;
        n_cmp++; if (dr1 !== 32'd200) begin n_bad++; $display("FAIL stored_dr1: got %0d expected 200", dr1); end
        n_cmp++; if (nb_dr1 !== 32'd200) begin n_bad++; $display("FAIL nobypass_stored: got %0d expected 200", nb_dr1); end
        step();
        aw = 5'd31; dw = 32'hDEADBEEF; enw = 1'b1; ar2 = 5'd31;
        #1;
        n_cmp++; if (dr2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bypass_dr2_top: got %0h expected deadbeef", dr2); end
        n_cmp++; if (nb_dr2 !== 32'd0) begin n_bad++; $display("FAIL nobypass_dr2_old: got %0h expected 0", nb_dr2); end
        step();
        enw = 1'b0;
        #1;
        n_cmp++; if (dr2 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stored_dr2_top: got %0h expected deadbeef", dr2); end
        n_cmp++; if (dr1 !== 32'd200) begin n_bad++; $display("FAIL keep_dr1: got %0d expected 200", dr1); end
    endtask

    task automatic test_zero_reg();
        step();
        aw = 5'd0; dw = 32'd55; enw = 1'b1; ar1 = 5'd0; ar2 = 5'd0;
        #1;
        n_cmp++; if (dr1 !== 32'd0) begin n_bad++; $display("FAIL zero_bypass: got %0d expected 0", dr1); end
        step();
        enw = 1'b0;
        #1;
        n_cmp++; if (dr1 !== 32'd0) begin n_bad++; $display("FAIL zero_stored_dr1: got %0d expected 0", dr1); end
        n_cmp++; if (nb_dr2 !== 32'd0) begin n_bad++; $display("FAIL zero_stored_dr2: got %0d expected 0", nb_dr2); end
    endtask

    task automatic test_fill();
        int cnt;
        logic [DW-1:0] exp;
        step();
        fill_req = 1'b1; fill_val = 32'd71; enw = 1'b1; aw = 5'd7; dw = 32'd123; ar1 = 5'd7;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_at_accept: got %b expected 0", busy); end
        step();
        fill_req = 1'b0; enw = 1'b0;
        #1;
        n_cmp++; if (dr1 !== 32'd123) begin n_bad++; $display("FAIL accept_cycle_write: got %0d expected 123", dr1); end
        n_cmp++; if (nb_busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_accept: got %b expected 1", nb_busy); end
        count_busy(cnt);
        n_cmp++; if (cnt !== 31) begin n_bad++; $display("FAIL fill_busy_cycles: got %0d expected 31", cnt); end
        n_cmp++; if (fill_done !== 1'b1) begin n_bad++; $display("FAIL fill_done_pulse: got %b expected 1", fill_done); end
        step();
        n_cmp++; if (fill_done !== 1'b0) begin n_bad++; $display("FAIL fill_done_single: got %b expected 0", fill_done); end
        for (int a = 0; a < DEPTH; a++) begin
            ar1 = AW'(a);
            ar2 = AW'(a);
            exp = (a == 0) ? 32'd0 : 32'd71;
            #1;
            n_cmp++; if (dr1 !== exp) begin n_bad++; $display("FAIL fill_entry[%0d]: got %0d expected %0d", a, dr1, exp); end
            n_cmp++; if (nb_dr2 !== exp) begin n_bad++; $display("FAIL fill_entry_nb[%0d]: got %0d expected %0d", a, nb_dr2, exp); end
        end
    endtask

    task automatic test_drop_during_fill();
        int cnt;
        step();
        fill_req = 1'b1; fill_val = 32'h0A0A;
        #1;
        step();
        fill_val = 32'd1234; enw = 1'b1; aw = 5'd5; dw = 32'd99; ar1 = 5'd5;
        #1;
        n_cmp++; if (dr1 !== 32'd71) begin n_bad++; $display("FAIL no_bypass_in_fill: got %0d expected 71", dr1); end
        n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL wr_drop_early: got %b expected 0", wr_drop); end
        step();
        enw = 1'b0; fill_req = 1'b0;
        #1;
        n_cmp++; if (wr_drop !== 1'b1 || nb_wr_drop !== 1'b1) begin n_bad++; $display("FAIL wr_drop_pulse: got %b expected 1", wr_drop); end
        step();
        n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL wr_drop_single: got %b expected 0", wr_drop); end
        count_busy(cnt);
        n_cmp++; if (cnt !== 29) begin n_bad++; $display("FAIL drop_remaining_busy: got %0d expected 29", cnt); end
        n_cmp++; if (fill_done !== 1'b1) begin n_bad++; $display("FAIL drop_fill_done: got %b expected 1", fill_done); end
        step();
        ar1 = 5'd5; ar2 = 5'd31;
        #1;
        n_cmp++; if (dr1 !== 32'h0A0A) begin n_bad++; $display("FAIL dropped_entry5: got %0h expected a0a", dr1); end
        n_cmp++; if (dr2 !== 32'h0A0A) begin n_bad++; $display("FAIL no_restart_entry31: got %0h expected a0a", dr2); end
        ar1 = 5'd1;
        #1;
        n_cmp++; if (dr1 !== 32'h0A0A) begin n_bad++; $display("FAIL drop_entry1: got %0h expected a0a", dr1); end
    endtask

    task automatic test_reset_mid_fill();
        int cnt;
        step();
        fill_req = 1'b1; fill_val = 32'h55;
        #1;
        step();
        fill_req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        ar1 = 5'd9; ar2 = 5'd10;
        #1;
        n_cmp++; if (dr1 !== 32'h55) begin n_bad++; $display("FAIL mid_fill_new: got %0h expected 55", dr1); end
        n_cmp++; if (dr2 !== 32'h0A0A) begin n_bad++; $display("FAIL mid_fill_old: got %0h expected a0a", dr2); end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
        for (int a = 0; a < DEPTH; a++) begin
            ar1 = AW'(a);
            ar2 = AW'(a);
            #1;
            n_cmp++; if (dr1 !== '0 || nb_dr2 !== '0) begin n_bad++; $display("FAIL abort_entry[%0d]: got %0h expected 0", a, dr1); end
        end
        step();
        rst = 1'b0;
        step();
        fill_req = 1'b1; fill_val = 32'd77;
        #1;
        step();
        fill_req = 1'b0; ar1 = 5'd1; ar2 = 5'd2;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b expected 1", busy); end
        n_cmp++; if (dr1 !== 32'd0) begin n_bad++; $display("FAIL restart_entry1_pending: got %0d expected 0", dr1); end
        step();
        n_cmp++; if (dr1 !== 32'd77) begin n_bad++; $display("FAIL restart_first_entry: got %0d expected 77", dr1); end
        n_cmp++; if (dr2 !== 32'd0) begin n_bad++; $display("FAIL restart_entry2_pending: got %0d expected 0", dr2); end
        count_busy(cnt);
        n_cmp++; if (cnt !== 30) begin n_bad++; $display("FAIL restart_remaining_busy: got %0d expected 30", cnt); end
        step();
        ar2 = 5'd31;
        #1;
        n_cmp++; if (dr2 !== 32'd77) begin n_bad++; $display("FAIL restart_last_entry: got %0d expected 77", dr2); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ar1 = '0; ar2 = '0; aw = '0; dw = '0; enw = 1'b0;
        fill_req = 1'b0; fill_val = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_fill();
        test_drop_during_fill();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
